// File: rtl/snd_pkg.sv
// Shared definitions for the 68k->Z80 sound command bridge.
package snd_pkg;

    localparam int unsigned STATUS_W     = 16;
    localparam int unsigned STAT_PENDING = 0;
    localparam int unsigned STAT_IRQ     = 1;

    // Encoding is {pending, irq}, so the state register bits are the flags.
    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        READ_IRQ = 2'b01,
        FULL_ACK = 2'b10,
        FULL_IRQ = 2'b11
    } state_t;

    function automatic logic state_pending(input state_t s);
        return s[1];
    endfunction

    function automatic logic state_irq(input state_t s);
        return s[0];
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector: one pulse per 0->1 transition of a level.
module edge_pulse (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic pulse
);

    logic level_q;
    logic level_qq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q  <= 1'b0;
            level_qq <= 1'b0;
        end else begin
            level_q  <= level;
            level_qq <= level_q;
        end
    end

    assign pulse = level_q & ~level_qq;

endmodule

// File: rtl/sound_latch_bridge.sv
// Sound command latch between the 68k and the Z80, with IRQ handshake and
// a mailbox status word readable by the 68k.
module sound_latch_bridge
    import snd_pkg::*;
#(
    parameter bit          ACK_CLEARS_IRQ = 1'b1,
    parameter int unsigned OVR_W          = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                m68k_latch_cs,
    input  logic                m68k_sound_cs,
    input  logic                m68k_lds_n,
    input  logic [15:0]         m68k_din,
    output logic [15:0]         m68k_dout,
    input  logic                z80_latch_cs,
    input  logic                RD_n,
    input  logic                WR_n,
    input  logic                M1_n,
    input  logic                IORQ_n,
    output logic [7:0]          z80_dout,
    output logic                z80_irq_n,
    output logic [OVR_W-1:0]    overrun_cnt
);

    logic   wr68_ev, rdz_ev, clrz_ev, ackz_ev;
    logic   irq_clr;
    logic   pend_nx, irq_nx;
    logic   [7:0] latch;
    state_t state;

    // The 68k samples the status register itself; its select needs no logic.
    logic unused_in;
    assign unused_in = &{1'b0, m68k_sound_cs, m68k_din[15:8]};

    edge_pulse u_wr68 (.clk(clk), .reset_n(reset_n),
                       .level(m68k_latch_cs & ~m68k_lds_n), .pulse(wr68_ev));
    edge_pulse u_rdz  (.clk(clk), .reset_n(reset_n),
                       .level(z80_latch_cs & ~RD_n),        .pulse(rdz_ev));
    edge_pulse u_clrz (.clk(clk), .reset_n(reset_n),
                       .level(z80_latch_cs & ~WR_n),        .pulse(clrz_ev));
    edge_pulse u_ackz (.clk(clk), .reset_n(reset_n),
                       .level(~M1_n & ~IORQ_n),             .pulse(ackz_ev));

    assign irq_clr = clrz_ev | (ACK_CLEARS_IRQ & ackz_ev);

    // A new command takes priority over both the read and the IRQ clear.
    always_comb begin
        pend_nx = state_pending(state);
        irq_nx  = state_irq(state);
        if (rdz_ev)  pend_nx = 1'b0;
        if (irq_clr) irq_nx  = 1'b0;
        if (wr68_ev) begin
            pend_nx = 1'b1;
            irq_nx  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= EMPTY;
            latch       <= '0;
            z80_dout    <= '0;
            overrun_cnt <= '0;
            m68k_dout   <= '0;
        end else begin
            state <= state_t'({pend_nx, irq_nx});
            if (wr68_ev)
                latch <= m68k_din[7:0];
            if (rdz_ev)
                z80_dout <= latch;
            // A write coinciding with a read is not an overrun: the read consumed the old byte.
            if (wr68_ev && state_pending(state) && !rdz_ev && overrun_cnt != '1)
                overrun_cnt <= overrun_cnt + 1'b1;
            m68k_dout               <= '0;
            m68k_dout[STAT_IRQ]     <= state_irq(state);
            m68k_dout[STAT_PENDING] <= state_pending(state);
        end
    end

    assign z80_irq_n = ~state_irq(state);

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Directed self-checking bench for sound_latch_bridge (both ACK_CLEARS_IRQ settings).
module tb_sound_latch_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m68k_latch_cs = 1'b0;
    logic        m68k_sound_cs = 1'b0;
    logic        m68k_lds_n = 1'b1;
    logic [15:0] m68k_din = '0;
    logic        z80_latch_cs = 1'b0;
    logic        RD_n = 1'b1;
    logic        WR_n = 1'b1;
    logic        M1_n = 1'b1;
    logic        IORQ_n = 1'b1;

    logic [15:0] m68k_dout_a, m68k_dout_b;
    logic [7:0]  z80_dout_a, z80_dout_b;
    logic        irq_n_a, irq_n_b;
    logic [7:0]  ovr_a, ovr_b;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    sound_latch_bridge #(.ACK_CLEARS_IRQ(1'b1), .OVR_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .m68k_latch_cs(m68k_latch_cs), .m68k_sound_cs(m68k_sound_cs),
        .m68k_lds_n(m68k_lds_n), .m68k_din(m68k_din), .m68k_dout(m68k_dout_a),
        .z80_latch_cs(z80_latch_cs), .RD_n(RD_n), .WR_n(WR_n),
        .M1_n(M1_n), .IORQ_n(IORQ_n),
        .z80_dout(z80_dout_a), .z80_irq_n(irq_n_a), .overrun_cnt(ovr_a)
    );

    sound_latch_bridge #(.ACK_CLEARS_IRQ(1'b0), .OVR_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .m68k_latch_cs(m68k_latch_cs), .m68k_sound_cs(m68k_sound_cs),
        .m68k_lds_n(m68k_lds_n), .m68k_din(m68k_din), .m68k_dout(m68k_dout_b),
        .z80_latch_cs(z80_latch_cs), .RD_n(RD_n), .WR_n(WR_n),
        .M1_n(M1_n), .IORQ_n(IORQ_n),
        .z80_dout(z80_dout_b), .z80_irq_n(irq_n_b), .overrun_cnt(ovr_b)
    );

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    endtask

    task automatic m68k_write(input logic [7:0] d, input int unsigned len);
        m68k_din = {8'hEE, d};
        m68k_latch_cs = 1'b1;
        m68k_lds_n = 1'b0;
        m68k_sound_cs = 1'b0;
        tick(len);
        m68k_latch_cs = 1'b0;
        m68k_lds_n = 1'b1;
        tick(3);
    endtask

    task automatic z80_read(input int unsigned len);
        z80_latch_cs = 1'b1;
        RD_n = 1'b0;
        tick(len);
        z80_latch_cs = 1'b0;
        RD_n = 1'b1;
        tick(3);
    endtask

    task automatic z80_write(input int unsigned len);
        z80_latch_cs = 1'b1;
        WR_n = 1'b0;
        tick(len);
        z80_latch_cs = 1'b0;
        WR_n = 1'b1;
        tick(3);
    endtask

    initial begin
        tick(2);
        chk("rst_status", m68k_dout_a, 16'h0000);
        chk("rst_irq_n", {15'd0, irq_n_a}, 16'h0001);
        chk("rst_z80_dout", {8'd0, z80_dout_a}, 16'h0000);
        chk("rst_overrun", {8'd0, ovr_a}, 16'h0000);
        reset_n = 1'b1;
        tick(2);

        // 68k write 0x5A held four cycles
        m68k_din = 16'hA55A;
        m68k_latch_cs = 1'b1;
        m68k_lds_n = 1'b0;
        tick(1);
        chk("wr_irq_n_edge", {15'd0, irq_n_a}, 16'h0001);
        tick(1);
        chk("wr_irq_n_next", {15'd0, irq_n_a}, 16'h0000);
        chk("wr_status_lag", m68k_dout_a, 16'h0000);
        m68k_sound_cs = 1'b1;
        tick(1);
        chk("wr_status", m68k_dout_a, 16'h0003);
        tick(1);
        m68k_latch_cs = 1'b0;
        m68k_lds_n = 1'b1;
        tick(3);
        chk("wr_single_event", {8'd0, ovr_a}, 16'h0000);
        chk("wr_status_hold", m68k_dout_a, 16'h0003);
        m68k_sound_cs = 1'b0;

        // Z80 read then Z80 write at 0xf800
        z80_read(3);
        chk("rd_z80_dout", {8'd0, z80_dout_a}, 16'h005A);
        chk("rd_status", m68k_dout_a, 16'h0002);
        z80_write(2);
        chk("clr_irq_n", {15'd0, irq_n_a}, 16'h0001);
        chk("clr_status", m68k_dout_a, 16'h0000);
        chk("clr_z80_dout_hold", {8'd0, z80_dout_a}, 16'h005A);

        // Overruns
        m68k_write(8'h01, 2);
        m68k_write(8'h02, 2);
        m68k_write(8'h03, 2);
        chk("ovr_two", {8'd0, ovr_a}, 16'h0002);
        z80_read(2);
        chk("ovr_latch", {8'd0, z80_dout_a}, 16'h0003);
        for (int i = 0; i < 300; i++)
            m68k_write(i[7:0], 2);
        chk("ovr_saturate", {8'd0, ovr_a}, 16'h00FF);
        chk("ovr_status", m68k_dout_a, 16'h0003);

        // IM1 acknowledge, both parameter settings
        M1_n = 1'b0;
        IORQ_n = 1'b0;
        tick(2);
        M1_n = 1'b1;
        IORQ_n = 1'b1;
        tick(3);
        chk("ack1_irq_n", {15'd0, irq_n_a}, 16'h0001);
        chk("ack1_status", m68k_dout_a, 16'h0001);
        chk("ack0_irq_n", {15'd0, irq_n_b}, 16'h0000);
        chk("ack0_status", m68k_dout_b, 16'h0003);

        // Fresh state, then simultaneous 68k write and Z80 read
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
        m68k_write(8'h11, 2);
        m68k_din = 16'h0077;
        m68k_latch_cs = 1'b1;
        m68k_lds_n = 1'b0;
        z80_latch_cs = 1'b1;
        RD_n = 1'b0;
        tick(2);
        m68k_latch_cs = 1'b0;
        m68k_lds_n = 1'b1;
        z80_latch_cs = 1'b0;
        RD_n = 1'b1;
        tick(3);
        chk("sim_z80_dout", {8'd0, z80_dout_a}, 16'h0011);
        chk("sim_status", m68k_dout_a, 16'h0003);
        chk("sim_irq_n", {15'd0, irq_n_a}, 16'h0000);
        chk("sim_overrun", {8'd0, ovr_a}, 16'h0000);
        z80_read(2);
        chk("sim_new_latch", {8'd0, z80_dout_a}, 16'h0077);

        // Reset in the middle of a 68k write
        m68k_din = 16'h003C;
        m68k_latch_cs = 1'b1;
        m68k_lds_n = 1'b0;
        tick(3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_irq_n", {15'd0, irq_n_a}, 16'h0001);
        chk("mid_rst_status", m68k_dout_a, 16'h0000);
        chk("mid_rst_z80_dout", {8'd0, z80_dout_a}, 16'h0000);
        tick(2);
        reset_n = 1'b1;
        tick(4);
        m68k_latch_cs = 1'b0;
        m68k_lds_n = 1'b1;
        tick(3);
        chk("post_rst_overrun", {8'd0, ovr_a}, 16'h0000);
        chk("post_rst_status", m68k_dout_a, 16'h0003);
        chk("post_rst_irq_n", {15'd0, irq_n_a}, 16'h0000);
        z80_read(2);
        chk("post_rst_latch", {8'd0, z80_dout_a}, 16'h003C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
